// File: rtl/jmb_kxk_window_stream.sv
`timescale 1ns/1ps
`default_nettype none
// jmb_kxk_window_stream: KxK sliding-window generator for raster-order pixel streams.
// Emits only windows lying fully inside the frame, tagged with the window-centre row/column.
module jmb_kxk_window_stream #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 100,
  parameter int K            = 3
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            in_valid,
  input  logic                            in_sof,
  input  logic [PIXEL_WIDTH-1:0]          in_data,
  output logic                            out_valid,
  output logic [K*K*PIXEL_WIDTH-1:0]      out_window,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  out_col,
  output logic                            frame_done
);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam logic [CW-1:0] C_COL_LAST  = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] C_COL_FIRST = CW'(K - 1);
  localparam logic [CW-1:0] C_COL_HALF  = CW'((K - 1) / 2);
  localparam logic [RW-1:0] C_ROW_LAST  = RW'(IMAGE_HEIGHT - 1);
  localparam logic [RW-1:0] C_ROW_FIRST = RW'(K - 1);
  localparam logic [RW-1:0] C_ROW_HALF  = RW'((K - 1) / 2);

  logic [CW-1:0]              col_q, col_d, col_cur;
  logic [RW-1:0]              row_q, row_d, row_cur;
  logic [PIXEL_WIDTH-1:0]     win_q [K][K];
  logic [PIXEL_WIDTH-1:0]     win_d [K][K];
  logic [PIXEL_WIDTH-1:0]     lb_rd [K-1];
  logic [K*K*PIXEL_WIDTH-1:0] win_flat;
  logic                       emit;
  logic                       last_pix;

  // A qualified start-of-frame forces the pixel to (0,0) regardless of the counters.
  assign col_cur = (in_valid && in_sof) ? '0 : col_q;
  assign row_cur = (in_valid && in_sof) ? '0 : row_q;

  assign emit     = in_valid && (row_cur >= C_ROW_FIRST) && (col_cur >= C_COL_FIRST);
  assign last_pix = in_valid && (row_cur == C_ROW_LAST) && (col_cur == C_COL_LAST);

  // Line buffer g holds line (row-1-g); reads return pre-write data at the same address.
  generate
    for (genvar g = 0; g < K - 1; g++) begin : g_linebuf
      logic [PIXEL_WIDTH-1:0] mem [IMAGE_WIDTH];
      assign lb_rd[g] = mem[col_cur];
      if (g == 0) begin : g_first
        always_ff @(posedge clock) begin
          if (reset_n && in_valid) mem[col_cur] <= in_data;
        end
      end else begin : g_chain
        always_ff @(posedge clock) begin
          if (reset_n && in_valid) mem[col_cur] <= lb_rd[g-1];
        end
      end
    end
  endgenerate

  always_comb begin
    win_d = win_q;
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        win_d[r][K-1] = lb_rd[K-2-r];
      end
      win_d[K-1][K-1] = in_data;
      if (col_cur == C_COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == C_ROW_LAST) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[((r*K)+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = win_d[r][c];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      col_q      <= '0;
      row_q      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_window <= '0;
      out_row    <= '0;
      out_col    <= '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      win_q      <= win_d;
      out_valid  <= emit;
      frame_done <= last_pix;
      if (emit) begin
        out_window <= win_flat;
        out_row    <= row_cur - C_ROW_HALF;
        out_col    <= col_cur - C_COL_HALF;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_jmb_kxk_window_stream.sv
`timescale 1ns/1ps
`default_nettype none
// tb_jmb_kxk_window_stream: randomized stimulus against a frame-array reference model,
// covering a K=3 (10x6) instance and a K=5 (8x6) instance.
module tb_jmb_kxk_window_stream;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_data;
  logic       sel;
  logic       v3, v5;
  assign v3 = in_valid & ~sel;
  assign v5 = in_valid & sel;

  logic        o3_valid, o3_done;
  logic [71:0] o3_win;
  logic [2:0]  o3_row;
  logic [3:0]  o3_col;
  logic        o5_valid, o5_done;
  logic [199:0] o5_win;
  logic [2:0]  o5_row;
  logic [2:0]  o5_col;

  jmb_kxk_window_stream #(.PIXEL_WIDTH(8), .IMAGE_WIDTH(10), .IMAGE_HEIGHT(6), .K(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .in_valid(v3), .in_sof(in_sof), .in_data(in_data),
    .out_valid(o3_valid), .out_window(o3_win), .out_row(o3_row), .out_col(o3_col),
    .frame_done(o3_done));

  jmb_kxk_window_stream #(.PIXEL_WIDTH(8), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(6), .K(5)) u_dut5 (
    .clock(clock), .reset_n(reset_n), .in_valid(v5), .in_sof(in_sof), .in_data(in_data),
    .out_valid(o5_valid), .out_window(o5_win), .out_row(o5_row), .out_col(o5_col),
    .frame_done(o5_done));

  logic         a_valid, a_done;
  logic [199:0] a_win;
  logic [3:0]   a_row, a_col;
  always_comb begin
    if (sel) begin
      a_valid = o5_valid; a_done = o5_done; a_win = o5_win;
      a_row = {1'b0, o5_row}; a_col = {1'b0, o5_col};
    end else begin
      a_valid = o3_valid; a_done = o3_done; a_win = {128'b0, o3_win};
      a_row = {1'b0, o3_row}; a_col = o3_col;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: the frame is stored as a 2-D image indexed by raster position.
  int W, H, K;
  int idx;
  logic [7:0]   pix [0:7][0:9];
  logic [199:0] last_win;
  logic [3:0]   last_row, last_col;
  int n_win, n_done;

  task automatic cycle(input bit v, input bit s, input logic [7:0] d);
    bit ev, ed;
    int r, c;
    @(negedge clock);
    in_valid = v; in_sof = s; in_data = d;
    ev = 0; ed = 0;
    if (v) begin
      if (s) idx = 0;
      r = idx / W;
      c = idx % W;
      pix[r][c] = d;
      if (r >= K - 1 && c >= K - 1) begin
        ev = 1;
        last_win = '0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            last_win[((i*K)+j)*8 +: 8] = pix[r-K+1+i][c-K+1+j];
        last_row = 4'(r - (K - 1) / 2);
        last_col = 4'(c - (K - 1) / 2);
        ed = (idx == W * H - 1);
      end
      idx = (idx + 1) % (W * H);
    end
    @(posedge clock); #1;
    check("out_valid", a_valid, ev);
    check("frame_done", a_done, ed);
    if (ev || !v) begin
      check("out_window", a_win, last_win);
      check("out_row", a_row, last_row);
      check("out_col", a_col, last_col);
    end
    if (a_valid) n_win++;
    if (a_done) n_done++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    in_data = 8'($urandom);
    @(posedge clock); #1;
    check("rst_valid", a_valid, 0);
    check("rst_done", a_done, 0);
    check("rst_window", a_win, 0);
    check("rst_row", a_row, 0);
    check("rst_col", a_col, 0);
    idx = 0; last_win = '0; last_row = '0; last_col = '0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // data_mode 0: raster index, 1: random. gap 0: none, 1: alternate idle, 2: random idle.
  task automatic frame(input int npix, input int data_mode, input int gap, input bit sof);
    logic [7:0] d;
    for (int p = 0; p < npix; p++) begin
      if (gap == 1 && p > 0) cycle(0, 1'($urandom), 8'($urandom));
      if (gap == 2) while ($urandom_range(0, 3) == 0) cycle(0, 1'($urandom), 8'($urandom));
      d = (data_mode == 0) ? 8'(p % 256) : 8'($urandom);
      cycle(1, sof && (p == 0), d);
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h0; sel = 1'b0;
    W = 10; H = 6; K = 3;
    repeat (2) @(posedge clock);
    do_reset();

    n_win = 0; n_done = 0;
    frame(60, 0, 0, 1);
    check("f1_windows", n_win, 32);
    check("f1_done", n_done, 1);

    n_win = 0; n_done = 0;
    frame(60, 1, 1, 1);
    check("gap_windows", n_win, 32);
    check("gap_done", n_done, 1);

    n_win = 0; n_done = 0;
    frame(60, 1, 2, 1);
    frame(60, 1, 2, 0);
    check("b2b_windows", n_win, 64);
    check("b2b_done", n_done, 2);

    n_done = 0;
    frame(35, 1, 2, 1);
    n_win = 0;
    frame(60, 1, 2, 1);
    check("abort_windows", n_win, 32);
    check("abort_done", n_done, 1);

    frame(30, 1, 0, 1);
    do_reset();
    n_win = 0; n_done = 0;
    frame(60, 1, 2, 1);
    check("postrst_windows", n_win, 32);
    check("postrst_done", n_done, 1);

    sel = 1'b1; W = 8; H = 6; K = 5;
    do_reset();
    n_win = 0; n_done = 0;
    frame(48, 0, 0, 1);
    check("k5_windows", n_win, 8);
    check("k5_done", n_done, 1);
    n_win = 0; n_done = 0;
    frame(48, 1, 2, 1);
    frame(48, 1, 2, 0);
    check("k5_rand_windows", n_win, 16);
    check("k5_rand_done", n_done, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
